// File: rtl/mpu_sequencer.sv
// Transaction sequencer for the MPU: fetches operands A and B from MemoryIO,
// waits for MpuOperations, then writes the result back and pulses done.
module mpu_sequencer #(
    parameter int DATA_W  = 200,
    parameter int ADDR_W  = 3,
    parameter int ADDR_A  = 0,
    parameter int ADDR_B  = 1,
    parameter int ADDR_R  = 2,
    parameter int MEM_LAT = 2,
    parameter int OP_LAT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op_sel,
    input  logic              size_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mat_a,
    output logic [DATA_W-1:0] mat_b,
    output logic [2:0]        op_code,
    output logic [7:0]        mat_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_o
);

    localparam int MAX_LAT = (MEM_LAT > OP_LAT) ? MEM_LAT : OP_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0]  MEM_RELOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]  OP_RELOAD  = CNT_W'(OP_LAT - 1);
    localparam logic [ADDR_W-1:0] A_ADDR     = ADDR_W'(ADDR_A);
    localparam logic [ADDR_W-1:0] B_ADDR     = ADDR_W'(ADDR_B);
    localparam logic [ADDR_W-1:0] R_ADDR     = ADDR_W'(ADDR_R);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign state_o = state;

    // The wait counter is reloaded on every state entry, so each phase counts
    // its own latency independently and never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_addr  <= A_ADDR;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
            mat_a     <= '0;
            mat_b     <= '0;
            op_code   <= 3'd0;
            mat_size  <= 8'd3;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    mem_addr <= A_ADDR;
                    if (start) begin
                        op_code  <= op_sel;
                        mat_size <= size_sel ? 8'd2 : 8'd3;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        wait_cnt <= MEM_RELOAD;
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    if (wait_cnt == '0) begin
                        mat_a    <= mem_rdata;
                        mem_addr <= B_ADDR;
                        wait_cnt <= MEM_RELOAD;
                        state    <= RD_B;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                // Illegal operations skip execution and write-back entirely.
                RD_B: begin
                    if (wait_cnt == '0) begin
                        mat_b <= mem_rdata;
                        if (op_code >= 3'd6) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            wait_cnt <= OP_RELOAD;
                            state    <= EXEC;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        mem_wdata <= result;
                        mem_addr  <= R_ADDR;
                        mem_wren  <= 1'b1;
                        state     <= WR;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WR: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy     <= 1'b0;
                    mem_addr <= A_ADDR;
                    state    <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    mem_addr <= A_ADDR;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
